bit_serial_subtractor: RTL and testbench

Multi-cycle bit-serial subtractor computing `a - b - borrow_in` one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the subtract-direction counterpart of the ripple-carry adder datapath and serves area-constrained paths where N-cycle latency is acceptable. A start/busy/done handshake sequences the operation, and the result is held stable until the next accepted start.

---
 rtl/bit_serial_subtractor_if.sv | 33 +++
 rtl/bit_serial_subtractor.sv | 103 ++++++++++
 tb/tb_bit_serial_subtractor.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_subtractor_if.sv
// Handshake/operand bundle for bit_serial_subtractor.
// The overflow signal exists only when SUB_OVERFLOW_EN is defined.
interface bit_serial_subtractor_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         borrow_in;
  logic [N-1:0] diff;
  logic         borrow_out;
  logic         busy;
  logic         done;
`ifdef SUB_OVERFLOW_EN
  logic         overflow;
`endif

  modport master (
    output start, a, b, borrow_in,
    input  diff, borrow_out, busy, done
`ifdef SUB_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  start, a, b, borrow_in,
    output diff, borrow_out, busy, done
`ifdef SUB_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/bit_serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one full-subtractor cell per clock.
// Optional signed overflow output is enabled by defining SUB_OVERFLOW_EN.
module bit_serial_subtractor #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bit_serial_subtractor_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_sh, b_sh, res_sh, diff_q;
  logic          br_q, borrow_q, busy_q, done_q;
  logic          accept, last;
  logic [1:0]    fs;
`ifdef SUB_OVERFLOW_EN
  logic          ovf_q;
`endif

  // Returns {borrow_next, difference_bit}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
    return {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
  endfunction

  // DONE also accepts, so a held start gives one operation per N+1 clocks.
  assign accept = bus.start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(N - 1));
  assign fs     = full_sub(a_sh[0], b_sh[0], br_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control flops: busy/done are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
    end
  end

  // Serial datapath; at the final bit a_sh[0]/b_sh[0] hold the operand MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      br_q     <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      br_q   <= bus.borrow_in;
      res_sh <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[N-1:1]};
      b_sh   <= {1'b0, b_sh[N-1:1]};
      br_q   <= fs[1];
      res_sh <= {fs[0], res_sh[N-1:1]};
      if (last) begin
        diff_q   <= {fs[0], res_sh[N-1:1]};
        borrow_q <= fs[1];
`ifdef SUB_OVERFLOW_EN
        ovf_q    <= (a_sh[0] != b_sh[0]) && (fs[0] != a_sh[0]);
`endif
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
`ifdef SUB_OVERFLOW_EN
  assign bus.overflow   = ovf_q;
`endif
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed bench for bit_serial_subtractor (N=8); overflow checks run when SUB_OVERFLOW_EN is defined.
module tb_bit_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nfail = 0;

  bit_serial_subtractor_if #(.N(8)) bus ();

  bit_serial_subtractor #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done; lat = clocks after accept, -1 on timeout.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic bi, output int lat);
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.borrow_in = bi; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if (bus.diff !== 8'h00) begin nfail++; $display("FAIL reset_diff got %h want 00", bus.diff); end
    nvec++; if (bus.borrow_out !== 1'b0) begin nfail++; $display("FAIL reset_borrow got %b want 0", bus.borrow_out); end
    nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    nvec++; if (bus.done !== 1'b0) begin nfail++; $display("FAIL reset_done got %b want 0", bus.done); end
`ifdef SUB_OVERFLOW_EN
    nvec++; if (bus.overflow !== 1'b0) begin nfail++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int busy_cnt, done_cnt, done_at;
    logic [7:0] d_at_done;
    logic       b_at_done;
    logic       hold_ok;
    busy_cnt = 0; done_cnt = 0; done_at = -1; hold_ok = 1'b1;
    d_at_done = 8'hxx; b_at_done = 1'bx;
    @(negedge clk);
    bus.a = 8'h5A; bus.b = 8'h3C; bus.borrow_in = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++; done_at = k; d_at_done = bus.diff; b_at_done = bus.borrow_out;
      end
      if (k < 8 && bus.diff !== 8'h00) hold_ok = 1'b0;
      @(negedge clk);
    end
    nvec++; if (d_at_done !== 8'h1E) begin nfail++; $display("FAIL basic_diff got %h want 1e", d_at_done); end
    nvec++; if (b_at_done !== 1'b0) begin nfail++; $display("FAIL basic_borrow got %b want 0", b_at_done); end
    nvec++; if (done_at !== 8) begin nfail++; $display("FAIL basic_latency got %0d want 8", done_at); end
    nvec++; if (done_cnt !== 1) begin nfail++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
    nvec++; if (busy_cnt !== 9) begin nfail++; $display("FAIL basic_busy_cycles got %0d want 9", busy_cnt); end
    nvec++; if (hold_ok !== 1'b1) begin nfail++; $display("FAIL basic_diff_hidden_in_run got %b want 1", hold_ok); end
    nvec++; if (bus.diff !== 8'h1E) begin nfail++; $display("FAIL basic_diff_hold got %h want 1e", bus.diff); end
  endtask

  task automatic test_borrow();
    int lat;
    do_op(8'h10, 8'h20, 1'b0, lat);
    nvec++; if (lat !== 8) begin nfail++; $display("FAIL borrow1_latency got %0d want 8", lat); end
    nvec++; if (bus.diff !== 8'hF0) begin nfail++; $display("FAIL borrow1_diff got %h want f0", bus.diff); end
    nvec++; if (bus.borrow_out !== 1'b1) begin nfail++; $display("FAIL borrow1_bout got %b want 1", bus.borrow_out); end
    do_op(8'h00, 8'h00, 1'b1, lat);
    nvec++; if (bus.diff !== 8'hFF) begin nfail++; $display("FAIL borrow2_diff got %h want ff", bus.diff); end
    nvec++; if (bus.borrow_out !== 1'b1) begin nfail++; $display("FAIL borrow2_bout got %b want 1", bus.borrow_out); end
    do_op(8'hFF, 8'h00, 1'b0, lat);
    nvec++; if (bus.diff !== 8'hFF) begin nfail++; $display("FAIL borrow3_diff got %h want ff", bus.diff); end
    nvec++; if (bus.borrow_out !== 1'b0) begin nfail++; $display("FAIL borrow3_bout got %b want 0", bus.borrow_out); end
    do_op(8'h00, 8'hFF, 1'b0, lat);
    nvec++; if (bus.diff !== 8'h01) begin nfail++; $display("FAIL borrow4_diff got %h want 01", bus.diff); end
    nvec++; if (bus.borrow_out !== 1'b1) begin nfail++; $display("FAIL borrow4_bout got %b want 1", bus.borrow_out); end
    do_op(8'h81, 8'h80, 1'b1, lat);
    nvec++; if (bus.diff !== 8'h00) begin nfail++; $display("FAIL borrow5_diff got %h want 00", bus.diff); end
    nvec++; if (bus.borrow_out !== 1'b0) begin nfail++; $display("FAIL borrow5_bout got %b want 0", bus.borrow_out); end
  endtask

`ifdef SUB_OVERFLOW_EN
  task automatic test_overflow();
    int lat;
    do_op(8'h80, 8'h01, 1'b0, lat);
    nvec++; if (bus.diff !== 8'h7F) begin nfail++; $display("FAIL ovf1_diff got %h want 7f", bus.diff); end
    nvec++; if (bus.overflow !== 1'b1) begin nfail++; $display("FAIL ovf1_flag got %b want 1", bus.overflow); end
    do_op(8'h05, 8'h03, 1'b0, lat);
    nvec++; if (bus.diff !== 8'h02) begin nfail++; $display("FAIL ovf2_diff got %h want 02", bus.diff); end
    nvec++; if (bus.overflow !== 1'b0) begin nfail++; $display("FAIL ovf2_flag got %b want 0", bus.overflow); end
    do_op(8'h7F, 8'hFF, 1'b0, lat);
    nvec++; if (bus.diff !== 8'h80) begin nfail++; $display("FAIL ovf3_diff got %h want 80", bus.diff); end
    nvec++; if (bus.overflow !== 1'b1) begin nfail++; $display("FAIL ovf3_flag got %b want 1", bus.overflow); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] prev, r1, r2;
    logic       b1, b2, hold_ok, busy_ok;
    int         ndone, d1, d2;
    prev = bus.diff;
    ndone = 0; d1 = -1; d2 = -1; hold_ok = 1'b1; busy_ok = 1'b1;
    r1 = 8'hxx; r2 = 8'hxx; b1 = 1'bx; b2 = 1'bx;
    @(negedge clk);
    bus.a = 8'h5A; bus.b = 8'h3C; bus.borrow_in = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      if (k == 3) begin bus.a = 8'h10; bus.b = 8'h20; end
      if (bus.done) begin
        ndone++;
        if (d1 < 0) begin d1 = k; r1 = bus.diff; b1 = bus.borrow_out; end
        else begin d2 = k; r2 = bus.diff; b2 = bus.borrow_out; end
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (k < 8 && bus.diff !== prev) hold_ok = 1'b0;
      if (k >= 9 && k < 17 && bus.diff !== 8'h1E) hold_ok = 1'b0;
      if (k == 17) bus.start = 1'b0;
      @(negedge clk);
    end
    nvec++; if (r1 !== 8'h1E) begin nfail++; $display("FAIL b2b_first_diff got %h want 1e", r1); end
    nvec++; if (b1 !== 1'b0) begin nfail++; $display("FAIL b2b_first_borrow got %b want 0", b1); end
    nvec++; if (d1 !== 8) begin nfail++; $display("FAIL b2b_first_done_at got %0d want 8", d1); end
    nvec++; if (d2 !== 17) begin nfail++; $display("FAIL b2b_second_done_at got %0d want 17", d2); end
    nvec++; if (ndone !== 2) begin nfail++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
    nvec++; if (r2 !== 8'hF0) begin nfail++; $display("FAIL b2b_second_diff got %h want f0", r2); end
    nvec++; if (b2 !== 1'b1) begin nfail++; $display("FAIL b2b_second_borrow got %b want 1", b2); end
    nvec++; if (hold_ok !== 1'b1) begin nfail++; $display("FAIL b2b_diff_hold got %b want 1", hold_ok); end
    nvec++; if (busy_ok !== 1'b1) begin nfail++; $display("FAIL b2b_busy_continuous got %b want 1", busy_ok); end
    repeat (2) @(negedge clk);
    nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL b2b_idle_after got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_abort();
    int lat, late_done;
    late_done = 0;
    @(negedge clk);
    bus.a = 8'h5A; bus.b = 8'h3C; bus.borrow_in = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    nvec++; if (bus.done !== 1'b0) begin nfail++; $display("FAIL abort_done got %b want 0", bus.done); end
    nvec++; if (bus.diff !== 8'h00) begin nfail++; $display("FAIL abort_diff got %h want 00", bus.diff); end
    nvec++; if (bus.borrow_out !== 1'b0) begin nfail++; $display("FAIL abort_borrow got %b want 0", bus.borrow_out); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus.done || bus.busy) late_done++;
      @(negedge clk);
    end
    nvec++; if (late_done !== 0) begin nfail++; $display("FAIL abort_no_done got %0d want 0", late_done); end
    do_op(8'h5A, 8'h3C, 1'b0, lat);
    nvec++; if (lat !== 8) begin nfail++; $display("FAIL abort_retry_latency got %0d want 8", lat); end
    nvec++; if (bus.diff !== 8'h1E) begin nfail++; $display("FAIL abort_retry_diff got %h want 1e", bus.diff); end
    nvec++; if (bus.borrow_out !== 1'b0) begin nfail++; $display("FAIL abort_retry_borrow got %b want 0", bus.borrow_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
`ifdef SUB_OVERFLOW_EN
    test_overflow();
`endif
    test_back_to_back();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
